baud_cfg_ctrl: RTL and testbench
================================

# baud_cfg_ctrl

Run-time configuration controller for the UART baud rate generator. Accepts new divider settings (`baud_freq`/`baud_limit`) over a valid/ready port and validates them. It quiesces the transmitter and receiver, clears the generator, applies the settings atomically, and reports `baud_ok` once the generator has produced a fixed number of `ce_16` ticks. It sits between the register/host interface and the baud generator, and gates the UART tx/rx datapaths through `uart_hold`.

## Interface
- `RESET_FREQ`, 576: `baud_freq` value loaded at reset (115200 baud at 50 MHz).
- `RESET_LIMIT`, 15049: `baud_limit` value loaded at reset.
- `SETTLE_TICKS`, 16: `ce_16` pulses counted after apply before `baud_ok`; legal range 1..255.
- `clock` in 1: single system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: a new configuration is presented.
- `cfg_ready` out 1: controller can accept a configuration.
- `cfg_freq` in 12: requested `baud_freq`.
- `cfg_limit` in 16: requested `baud_limit`.
- `cfg_err` out 1: one-cycle pulse when an accepted configuration is rejected.
- `tx_busy` in 1: transmitter mid-frame.
- `rx_busy` in 1: receiver mid-frame.
- `ce_16` in 1: tick from the baud generator.
- `baud_freq` out 12: divider setting driven to the generator.
- `baud_limit` out 16: divider setting driven to the generator.
- `gen_clr` out 1: active-high clear to the baud generator.
- `uart_hold` out 1: tx/rx must not start a new frame while high.
- `baud_ok` out 1: generator is running on the current settings.

## Operation
- States: IDLE, DRAIN, CLEAR, SETTLE.
- Reset values:
  - state SETTLE, settle counter 0, clear counter 0
  - `baud_freq`=RESET_FREQ, `baud_limit`=RESET_LIMIT
  - `gen_clr`=0, `cfg_ready`=0, `cfg_err`=0, `uart_hold`=1, `baud_ok`=0
- Handshake: a transfer occurs on a rising edge where `cfg_valid`=1 and `cfg_ready`=1. `cfg_ready`=1 only in IDLE.
- Validation at the transfer edge. Reject if any of:
  - `cfg_freq`==0
  - `cfg_limit`==0
  - `cfg_freq`>`cfg_limit` (ce_16 faster than every other cycle)
- Rejected transfer: `cfg_err`=1 for exactly the next cycle. State stays IDLE, outputs otherwise unchanged, `baud_ok` unaffected.
- Valid transfer: `cfg_freq`/`cfg_limit` are latched into shadow registers. Then next state DRAIN, `cfg_ready`=0, `uart_hold`=1, `baud_ok`=0.
- DRAIN: wait, with no timeout, until `tx_busy`=0 and `rx_busy`=0 are sampled in the same cycle. On that edge:
  - go to CLEAR
  - `gen_clr`=1
  - `baud_freq`/`baud_limit` are loaded from the shadows (both on the same edge)
- CLEAR: exactly 2 cycles with `gen_clr`=1. Then SETTLE, with `gen_clr`=0 and settle counter 0.
- SETTLE:
  - The counter increments on each cycle where `ce_16`=1 is sampled while in SETTLE.
  - `ce_16` in any other state is ignored.
  - When the increment reaches SETTLE_TICKS: go to IDLE, `baud_ok`=1, `uart_hold`=0, `cfg_ready`=1.
- `tx_busy`/`rx_busy` are ignored outside DRAIN.
- `cfg_valid` is ignored outside IDLE; no queuing.
- `baud_freq`/`baud_limit` never change except on the DRAIN→CLEAR edge or at reset.
- Reset mid-operation: shadows are discarded and outputs return to their reset values immediately (asynchronously). Settings revert to RESET_FREQ/RESET_LIMIT.

## Timing
- Transfer edge T0 → DRAIN from T0. `cfg_ready`=0, `uart_hold`=1, `baud_ok`=0 are visible in cycle T0+1.
- Minimum DRAIN is 1 cycle. With both busy signals low at T0+1, the sequence is:
  - `gen_clr` and new settings valid in cycles T0+2..T0+3
  - SETTLE from T0+4
- After SETTLE entry, `baud_ok` rises on the edge that samples the SETTLE_TICKS-th `ce_16`. It is visible in the cycle after that sample.
- Rejection: `cfg_err` is high only in cycle T0+1, and `cfg_ready` stays 1.
- Back-to-back: `cfg_valid` held high across an IDLE period produces one transfer per IDLE cycle. Each rejected request can be followed by another transfer in the next cycle.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- Reset release with `ce_16` pulsing every 4th cycle and SETTLE_TICKS=16:
  - `baud_freq`=576, `baud_limit`=15049 throughout
  - `baud_ok`=0 and `uart_hold`=1 until the 16th pulse, then `baud_ok`=1 and `cfg_ready`=1
- From IDLE, apply cfg 1152/14473 with both busy signals low:
  - `gen_clr`=1 for exactly 2 cycles starting T0+2
  - outputs 1152/14473 from T0+2
  - `baud_ok` low until 16 `ce_16` pulses have been counted
- Apply cfg with `tx_busy`=1 for 50 cycles:
  - state remains DRAIN, `uart_hold`=1, `baud_freq` stays 576
  - CLEAR begins the cycle after `tx_busy` falls (with `rx_busy`=0)
- Reject cases: cfg 0/100, 100/0, and 2000/1000:
  - each gives a `cfg_err` single-cycle pulse
  - `cfg_ready` stays 1, settings and `baud_ok` unchanged
- Assert `reset_n`=0 in the middle of SETTLE after a 1152/14473 apply:
  - outputs revert immediately to 576/15049, `baud_ok`=0, `uart_hold`=1, `gen_clr`=0
  - after release, a fresh settle of 16 ticks is required
- `cfg_valid`=1 during DRAIN, CLEAR, and SETTLE:
  - no transfer and no `cfg_err`
  - the first transfer occurs on the first IDLE cycle

Source files
------------

// File: rtl/baud_cfg_ctrl_if.sv
// Configuration port between the host/register side and the baud
// configuration controller: valid/ready transfer plus a reject pulse.
interface baud_cfg_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [11:0] cfg_freq;
  logic [15:0] cfg_limit;
  logic        cfg_err;

  modport master (
    output cfg_valid,
    output cfg_freq,
    output cfg_limit,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_freq,
    input  cfg_limit,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/baud_cfg_ctrl.sv
// Run-time baud configuration controller. Accepts and validates new
// divider settings, drains tx/rx, clears the generator, applies both
// settings on one edge, then waits a fixed number of ce_16 ticks before
// reporting baud_ok. All outputs are registered.
module baud_cfg_ctrl #(
  parameter logic [11:0] RESET_FREQ   = 12'd576,
  parameter logic [15:0] RESET_LIMIT  = 16'd15049,
  parameter int unsigned SETTLE_TICKS = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  baud_cfg_ctrl_if.slave        cfg,
  input  logic                  tx_busy,
  input  logic                  rx_busy,
  input  logic                  ce_16,
  output logic [11:0]           baud_freq,
  output logic [15:0]           baud_limit,
  output logic                  gen_clr,
  output logic                  uart_hold,
  output logic                  baud_ok
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, SETTLE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS);

  state_t      state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic        clr_cnt_q, clr_cnt_d;
  logic [11:0] shadow_freq_q, shadow_freq_d;
  logic [15:0] shadow_limit_q, shadow_limit_d;
  logic [11:0] freq_q, freq_d;
  logic [15:0] limit_q, limit_d;
  logic        gen_clr_q, gen_clr_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;
  logic        ok_q, ok_d;
  logic        cfg_bad;

  // Reject zero dividers and ratios that would tick faster than every other cycle.
  always_comb begin
    cfg_bad = (cfg.cfg_freq == '0) || (cfg.cfg_limit == '0) ||
              ({4'b0000, cfg.cfg_freq} > cfg.cfg_limit);
  end

  // State and registered-output storage; reset leaves the generator settling on defaults.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SETTLE;
      settle_cnt_q   <= '0;
      clr_cnt_q      <= 1'b0;
      shadow_freq_q  <= RESET_FREQ;
      shadow_limit_q <= RESET_LIMIT;
      freq_q         <= RESET_FREQ;
      limit_q        <= RESET_LIMIT;
      gen_clr_q      <= 1'b0;
      ready_q        <= 1'b0;
      err_q          <= 1'b0;
      hold_q         <= 1'b1;
      ok_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      shadow_freq_q  <= shadow_freq_d;
      shadow_limit_q <= shadow_limit_d;
      freq_q         <= freq_d;
      limit_q        <= limit_d;
      gen_clr_q      <= gen_clr_d;
      ready_q        <= ready_d;
      err_q          <= err_d;
      hold_q         <= hold_d;
      ok_q           <= ok_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    clr_cnt_d      = clr_cnt_q;
    shadow_freq_d  = shadow_freq_q;
    shadow_limit_d = shadow_limit_q;
    freq_d         = freq_q;
    limit_d        = limit_q;
    gen_clr_d      = gen_clr_q;
    ready_d        = ready_q;
    err_d          = 1'b0;
    hold_d         = hold_q;
    ok_d           = ok_q;
    unique case (state_q)
      IDLE: begin
        if (cfg.cfg_valid && ready_q) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            shadow_freq_d  = cfg.cfg_freq;
            shadow_limit_d = cfg.cfg_limit;
            state_d        = DRAIN;
            ready_d        = 1'b0;
            hold_d         = 1'b1;
            ok_d           = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy && !rx_busy) begin
          state_d   = CLEAR;
          gen_clr_d = 1'b1;
          clr_cnt_d = 1'b0;
          freq_d    = shadow_freq_q;
          limit_d   = shadow_limit_q;
        end
      end
      CLEAR: begin
        if (clr_cnt_q) begin
          state_d      = SETTLE;
          gen_clr_d    = 1'b0;
          settle_cnt_d = '0;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      SETTLE: begin
        if (ce_16) begin
          settle_cnt_d = settle_cnt_q + 8'd1;
          if (settle_cnt_q + 8'd1 == SETTLE_LAST) begin
            state_d = IDLE;
            ok_d    = 1'b1;
            hold_d  = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign baud_freq     = freq_q;
  assign baud_limit    = limit_q;
  assign gen_clr       = gen_clr_q;
  assign uart_hold     = hold_q;
  assign baud_ok       = ok_q;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Self-checking bench for baud_cfg_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against
// a behavioural model of the configuration sequence.
module tb_baud_cfg_ctrl;

  localparam int TICKS = 16;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        tx_busy = 1'b0;
  logic        rx_busy = 1'b0;
  logic        ce_16   = 1'b0;
  logic [11:0] baud_freq;
  logic [15:0] baud_limit;
  logic        gen_clr;
  logic        uart_hold;
  logic        baud_ok;

  baud_cfg_ctrl_if bus ();

  baud_cfg_ctrl #(
    .RESET_FREQ  (12'd576),
    .RESET_LIMIT (16'd15049),
    .SETTLE_TICKS(TICKS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg       (bus),
    .tx_busy   (tx_busy),
    .rx_busy   (rx_busy),
    .ce_16     (ce_16),
    .baud_freq (baud_freq),
    .baud_limit(baud_limit),
    .gen_clr   (gen_clr),
    .uart_hold (uart_hold),
    .baud_ok   (baud_ok)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ce_16 source: 0 = every 4th cycle, 1 = random, other = silent
  int ce_mode  = 0;
  int ce_phase = 0;
  always @(posedge clock) begin
    #3;
    ce_phase++;
    case (ce_mode)
      0:       ce_16 = (ce_phase % 4 == 0);
      1:       ce_16 = ($urandom % 3 == 0);
      default: ce_16 = 1'b0;
    endcase
  end

  // running count of ce_16 pulses seen by the DUT out of reset
  int ce_seen = 0;
  always @(posedge clock) if (reset_n && ce_16) ce_seen = ce_seen + 1;

  // Behavioural model: a request is either pending drain, being cleared for a
  // number of cycles, or waiting for a number of ticks; otherwise we are open.
  bit          m_rdy, m_err, m_clr, m_hold, m_ok;
  logic [11:0] m_freq, p_freq;
  logic [15:0] m_limit, p_limit;
  bit          draining;
  int          clear_left, ticks_left;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rdy = 0; m_err = 0; m_clr = 0; m_hold = 1; m_ok = 0;
      m_freq = 12'd576; m_limit = 16'd15049;
      draining = 0; clear_left = 0; ticks_left = TICKS;
    end else begin
      m_err = 0;
      if (m_rdy) begin
        if (bus.cfg_valid) begin
          if (bus.cfg_freq == 0 || bus.cfg_limit == 0 ||
              int'(bus.cfg_freq) > int'(bus.cfg_limit)) begin
            m_err = 1;
          end else begin
            p_freq = bus.cfg_freq; p_limit = bus.cfg_limit;
            draining = 1; m_rdy = 0; m_hold = 1; m_ok = 0;
          end
        end
      end else if (draining) begin
        if (!tx_busy && !rx_busy) begin
          draining = 0; clear_left = 2; m_clr = 1;
          m_freq = p_freq; m_limit = p_limit;
        end
      end else if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          m_clr = 0; ticks_left = TICKS;
        end
      end else if (ce_16) begin
        ticks_left--;
        if (ticks_left == 0) begin
          m_ok = 1; m_hold = 0; m_rdy = 1;
        end
      end
    end
  end

  // Compare every cycle on the inactive edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("baud_freq",  32'(baud_freq),     32'(m_freq));
      chk("baud_limit", 32'(baud_limit),    32'(m_limit));
      chk("gen_clr",    32'(gen_clr),       32'(m_clr));
      chk("uart_hold",  32'(uart_hold),     32'(m_hold));
      chk("baud_ok",    32'(baud_ok),       32'(m_ok));
      chk("cfg_ready",  32'(bus.cfg_ready), 32'(m_rdy));
      chk("cfg_err",    32'(bus.cfg_err),   32'(m_err));
    end
  end

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic send(input logic [11:0] f, input logic [15:0] l);
    bus.cfg_valid = 1'b1;
    bus.cfg_freq  = f;
    bus.cfg_limit = l;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_ok(input int max, input string nm);
    int n = 0;
    while (!baud_ok && n < max) begin
      step();
      n++;
    end
    chk(nm, 32'(baud_ok), 32'd1);
  endtask

  int base;
  logic [11:0] rf [3] = '{12'd0, 12'd100, 12'd2000};
  logic [15:0] rl [3] = '{16'd100, 16'd0, 16'd1000};

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_freq  = '0;
    bus.cfg_limit = '0;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1;
    repeat (3) step();
    chk("rst_freq",  32'(baud_freq),     32'd576);
    chk("rst_limit", 32'(baud_limit),    32'd15049);
    chk("rst_hold",  32'(uart_hold),     32'd1);
    chk("rst_ok",    32'(baud_ok),       32'd0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_clr",   32'(gen_clr),       32'd0);
    reset_n = 1'b1;
    base = ce_seen;
    wait_ok(200, "settle_after_reset");
    chk("reset_ticks", 32'(ce_seen - base), 32'd16);
    chk("reset_ready", 32'(bus.cfg_ready), 32'd1);
    chk("reset_freq",  32'(baud_freq),     32'd576);

    // apply 1152/14473 with both busy low
    send(12'd1152, 16'd14473);
    chk("apply_ready_low", 32'(bus.cfg_ready), 32'd0);
    chk("apply_hold",      32'(uart_hold),     32'd1);
    chk("apply_clr_t1",    32'(gen_clr),       32'd0);
    step();
    chk("apply_clr_t2",    32'(gen_clr),       32'd1);
    chk("apply_freq",      32'(baud_freq),     32'd1152);
    chk("apply_limit",     32'(baud_limit),    32'd14473);
    step();
    chk("apply_clr_t3",    32'(gen_clr),       32'd1);
    step();
    chk("apply_clr_t4",    32'(gen_clr),       32'd0);
    base = ce_seen;
    wait_ok(300, "apply_settle");
    chk("apply_ticks", 32'(ce_seen - base), 32'd16);

    // reset in the middle of SETTLE
    send(12'd1152, 16'd14473);
    repeat (23) step();
    chk("mid_ok_low", 32'(baud_ok), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_freq",  32'(baud_freq),  32'd576);
    chk("mid_rst_limit", 32'(baud_limit), 32'd15049);
    chk("mid_rst_ok",    32'(baud_ok),    32'd0);
    chk("mid_rst_hold",  32'(uart_hold),  32'd1);
    chk("mid_rst_clr",   32'(gen_clr),    32'd0);
    step();
    step();
    reset_n = 1'b1;
    base = ce_seen;
    wait_ok(300, "mid_rst_settle");
    chk("mid_rst_ticks", 32'(ce_seen - base), 32'd16);

    // drain held by tx_busy for 50 cycles
    tx_busy = 1'b1;
    send(12'd1152, 16'd14473);
    repeat (50) step();
    chk("drain_freq", 32'(baud_freq), 32'd576);
    chk("drain_hold", 32'(uart_hold), 32'd1);
    chk("drain_clr",  32'(gen_clr),   32'd0);
    tx_busy = 1'b0;
    step();
    chk("drain_clr_after", 32'(gen_clr),   32'd1);
    chk("drain_freq_after", 32'(baud_freq), 32'd1152);
    wait_ok(300, "drain_settle");

    // rejects, one at a time
    for (int i = 0; i < 3; i++) begin
      send(rf[i], rl[i]);
      chk("rej_err",   32'(bus.cfg_err),   32'd1);
      chk("rej_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rej_ok",    32'(baud_ok),       32'd1);
      chk("rej_freq",  32'(baud_freq),     32'd1152);
      step();
      chk("rej_err_end", 32'(bus.cfg_err), 32'd0);
    end
    // rejects back to back with valid held
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cfg_freq  = rf[i];
      bus.cfg_limit = rl[i];
      step();
      chk("b2b_err", 32'(bus.cfg_err), 32'd1);
    end
    // equal freq/limit is legal and follows immediately
    bus.cfg_freq  = 12'd300;
    bus.cfg_limit = 16'd300;
    step();
    bus.cfg_valid = 1'b0;
    chk("eq_err",   32'(bus.cfg_err),   32'd0);
    chk("eq_ready", 32'(bus.cfg_ready), 32'd0);
    wait_ok(300, "eq_settle");
    chk("eq_freq", 32'(baud_freq), 32'd300);

    // valid held through DRAIN/CLEAR/SETTLE: only one transfer per IDLE
    send(12'd1152, 16'd14473);
    bus.cfg_valid = 1'b1;
    bus.cfg_freq  = 12'd2000;
    bus.cfg_limit = 16'd40000;
    tx_busy = 1'b1;
    repeat (5) step();
    tx_busy = 1'b0;
    begin
      int n = 0;
      while (!bus.cfg_ready && n < 300) begin
        step();
        n++;
      end
    end
    chk("hold_idle_reached", 32'(bus.cfg_ready), 32'd1);
    chk("hold_idle_freq",    32'(baud_freq),     32'd1152);
    step();
    bus.cfg_valid = 1'b0;
    chk("hold_xfer_ready", 32'(bus.cfg_ready), 32'd0);
    chk("hold_xfer_ok",    32'(baud_ok),       32'd0);
    wait_ok(300, "hold_settle");
    chk("hold_freq", 32'(baud_freq), 32'd2000);

    // randomized phase
    ce_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.cfg_valid = ($urandom % 4 == 0);
      bus.cfg_freq  = ($urandom % 8 == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      bus.cfg_limit = ($urandom % 8 == 0) ? 16'd0 :
                      (($urandom % 2) != 0) ? 16'($urandom_range(0, 65535))
                                            : 16'($urandom_range(0, 4095));
      tx_busy = ($urandom % 3 == 0);
      rx_busy = ($urandom % 3 == 0);
      if ($urandom % 600 == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end
    bus.cfg_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
